// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
package seq_tx_pkg;

  localparam int DEF_MAX_LEN    = 8;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int HIT_CNT_W      = 8;
  localparam int REPS_W         = 4;
  localparam int GAP_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Repetitions still owed after the one that starts on acceptance; a
  // request of zero behaves like a single pass.
  function automatic logic [REPS_W-1:0] reps_remaining(input logic [REPS_W-1:0] reps);
    return (reps == '0) ? '0 : reps - REPS_W'(1);
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shifter. The captured pattern is left-aligned so the
// next bit to send always sits in the top position, whatever the length.
// The aligned copy is kept so each repetition can restart from it.
module seq_tx_shreg import seq_tx_pkg::*; #(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               reload,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  output logic               bit_out,
  output logic               last
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] sh_q, sh_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   align_amt;
  logic [MAX_LEN-1:0] pat_aligned;

  // Next shifter contents: new capture, restart of the captured pattern, or one-bit advance.
  always_comb begin
    align_amt   = LEN_W'(MAX_LEN) - length;
    pat_aligned = pattern << align_amt;
    pat_d       = pat_q;
    sh_d        = sh_q;
    len_d       = len_q;
    idx_d       = idx_q;
    if (load) begin
      pat_d = pat_aligned;
      sh_d  = pat_aligned;
      len_d = length;
      idx_d = length - LEN_W'(1);
    end else if (reload) begin
      sh_d  = pat_q;
      idx_d = len_q - LEN_W'(1);
    end else if (shift && (idx_q != '0)) begin
      sh_d  = {sh_q[MAX_LEN-2:0], 1'b0};
      idx_d = idx_q - LEN_W'(1);
    end
  end

  // Shifter state registers; reset clears every captured value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= '0;
      sh_q  <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      pat_q <= pat_d;
      sh_q  <= sh_d;
      len_q <= len_d;
      idx_q <= idx_d;
    end
  end

  assign bit_out = sh_q[MAX_LEN-1];
  assign last    = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured bit pattern MSB first a
// number of times with idle gaps between repetitions, and counts the match
// pulses returned by a downstream detector while the transfer is running.
module seq_pattern_tx import seq_tx_pkg::*; #(
  parameter  int MAX_LEN    = DEF_MAX_LEN,
  parameter  int GAP_CYCLES = DEF_GAP_CYCLES,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [MAX_LEN-1:0]   pattern,
  input  logic [LEN_W-1:0]     length,
  input  logic [REPS_W-1:0]    reps,
  input  logic                 hit,
  output logic                 sdata,
  output logic                 svalid,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [HIT_CNT_W-1:0] hit_count
);

  localparam logic [GAP_W-1:0]     GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [HIT_CNT_W-1:0] HIT_MAX  = '1;

  state_e                state_q, state_d;
  logic                  svalid_q, svalid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [REPS_W-1:0]     reps_left_q, reps_left_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [HIT_CNT_W-1:0]  hit_cnt_q, hit_cnt_d;

  logic                  len_ok;
  logic                  accept;
  logic                  sh_load, sh_reload, sh_shift;
  logic                  sh_bit, sh_last;

  seq_tx_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shreg (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (sh_load),
    .reload  (sh_reload),
    .shift   (sh_shift),
    .pattern (pattern),
    .length  (length),
    .bit_out (sh_bit),
    .last    (sh_last)
  );

  assign len_ok = (length != '0) && (length <= LEN_W'(MAX_LEN));

  // Next state and next registered outputs; outputs describe the cycle after the edge.
  always_comb begin
    state_d     = state_q;
    svalid_d    = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    reps_left_d = reps_left_q;
    gap_d       = gap_q;
    accept      = 1'b0;
    sh_load     = 1'b0;
    sh_reload   = 1'b0;
    sh_shift    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok) begin
            accept      = 1'b1;
            sh_load     = 1'b1;
            reps_left_d = reps_remaining(reps);
            state_d     = ST_SHIFT;
            svalid_d    = 1'b1;
            busy_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (!sh_last) begin
          sh_shift = 1'b1;
          svalid_d = 1'b1;
        end else if (reps_left_q != '0) begin
          reps_left_d = reps_left_q - REPS_W'(1);
          if (GAP_CYCLES == 0) begin
            // Back-to-back repetitions: restart the pattern without leaving SHIFT.
            sh_reload = 1'b1;
            svalid_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LAST;
          end
        end else begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_q == '0) begin
          state_d   = ST_SHIFT;
          sh_reload = 1'b1;
          svalid_d  = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      ST_DONE: begin
        // A start seen here is dropped; the next one is taken in IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Hit counter: cleared on acceptance (a same-cycle hit is not counted), saturating, held while idle.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (accept) begin
      hit_cnt_d = '0;
    end else if (busy_q && hit && (hit_cnt_q != HIT_MAX)) begin
      hit_cnt_d = hit_cnt_q + HIT_CNT_W'(1);
    end
  end

  // FSM, counters and registered outputs; reset aborts any transfer without a done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      svalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      reps_left_q <= '0;
      gap_q       <= '0;
      hit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      svalid_q    <= svalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      reps_left_q <= reps_left_d;
      gap_q       <= gap_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

  // The shifter's top bit is only meaningful while a pattern bit is being sent.
  assign sdata     = svalid_q & sh_bit;
  assign svalid    = svalid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign hit_count = hit_cnt_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed scenarios plus random traffic, each
// cycle compared against a transaction-level model that expands an accepted
// request into its expected per-cycle output sequence.
module tb_seq_pattern_tx;

  localparam int MAXL = 16;
  localparam int GAP  = 2;
  localparam int LW   = $clog2(MAXL + 1);

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            hit_drv = 1'b0;
  logic            loop_mode = 1'b0;
  logic            hit;
  logic [MAXL-1:0] pattern = '0;
  logic [LW-1:0]   length = '0;
  logic [3:0]      reps = '0;
  logic            sdata, svalid, busy, done, err;
  logic [7:0]      hit_count;
  logic            det_s0, det_s1, hit_det;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected-output queue, entries {busy, done, svalid, sdata}
  logic [3:0] exp_q[$];
  logic [3:0] cur = 4'b0;
  logic       m_err = 1'b0;
  int         m_cnt = 0;

  int          busy_n, done_n, err_n, bits_n, det_n;
  logic [31:0] bits;

  always #5 clock = ~clock;

  seq_pattern_tx #(
    .MAX_LEN    (MAXL),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .pattern   (pattern),
    .length    (length),
    .reps      (reps),
    .hit       (hit),
    .sdata     (sdata),
    .svalid    (svalid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .hit_count (hit_count)
  );

  // Mealy 111 detector: Y = A & S0 & S1 on the serial stream
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      det_s0 <= 1'b0;
      det_s1 <= 1'b0;
    end else begin
      det_s1 <= det_s0;
      det_s0 <= sdata;
    end
  end
  assign hit_det = sdata & det_s0 & det_s1;
  assign hit     = loop_mode ? hit_det : hit_drv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_busy(input int len, input int r);
    int re;
    re = (r == 0) ? 1 : r;
    return re * len + (re - 1) * GAP;
  endfunction

  function automatic void build(input logic [MAXL-1:0] p, input int len, input int r);
    int re;
    re = (r == 0) ? 1 : r;
    for (int k = 0; k < re; k++) begin
      for (int i = len - 1; i >= 0; i--) exp_q.push_back({1'b1, 1'b0, 1'b1, p[i]});
      if (k < re - 1)
        for (int g = 0; g < GAP; g++) exp_q.push_back(4'b1000);
    end
    exp_q.push_back(4'b0100);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    cur   = 4'b0;
    m_err = 1'b0;
    m_cnt = 0;
  endfunction

  task automatic clear_tally();
    busy_n = 0; done_n = 0; err_n = 0; bits_n = 0; det_n = 0; bits = '0;
  endtask

  // One clock: capture inputs mid-cycle, advance model at the edge, compare after it.
  task automatic step();
    logic            s_start, s_hit;
    logic [MAXL-1:0] s_pat;
    logic [LW-1:0]   s_len;
    logic [3:0]      s_reps;
    logic            idle, acc;
    @(negedge clock);
    s_start = start; s_hit = hit; s_pat = pattern; s_len = length; s_reps = reps;
    if (hit_det && busy) det_n++;
    @(posedge clock);
    #1;
    idle  = (exp_q.size() == 0) && !cur[2];
    acc   = idle && s_start && (s_len != 0) && (int'(s_len) <= MAXL);
    m_err = idle && s_start && !acc;
    if (acc) m_cnt = 0;
    else if (cur[3] && s_hit && m_cnt < 255) m_cnt++;
    if (acc) build(s_pat, int'(s_len), int'(s_reps));
    cur = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0;
    chk("outs", 32'({sdata, svalid, busy, done, err}), 32'({cur[0], cur[1], cur[3], cur[2], m_err}));
    chk("hit_count", 32'(hit_count), 32'(m_cnt));
    busy_n += int'(busy);
    done_n += int'(done);
    err_n  += int'(err);
    if (svalid) begin
      bits = {bits[30:0], sdata};
      bits_n++;
    end
  endtask

  // Issue one request, run until done (bounded), then one idle cycle.
  task automatic run_xfer(input logic [MAXL-1:0] p, input int len, input int r);
    clear_tally();
    pattern = p; length = LW'(len); reps = 4'(r); start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 1000 && done_n == 0; c++) step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_tally();
    @(posedge clock); @(posedge clock); #1;
    chk("reset_outs", 32'({sdata, svalid, busy, done, err}), 32'd0);
    chk("reset_hitcnt", 32'(hit_count), 32'd0);
    reset_n = 1'b1;
    model_reset();

    // Single 3-bit pass accepted on the first edge after reset release
    run_xfer(16'h0007, 3, 1);
    chk("t1_bits", bits, 32'h7);
    chk("t1_nbits", 32'(bits_n), 32'd3);
    chk("t1_busy", 32'(busy_n), 32'(exp_busy(3, 1)));
    chk("t1_done", 32'(done_n), 32'd1);

    // Two repetitions of 101 with gap
    run_xfer(16'b101, 3, 2);
    chk("t2_bits", bits, 32'b101101);
    chk("t2_busy", 32'(busy_n), 32'd8);
    chk("t2_done", 32'(done_n), 32'd1);

    // Rejected starts: length 0 and length above MAX_LEN
    clear_tally();
    length = '0; start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    length = LW'(MAXL + 1); start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("err_pulses", 32'(err_n), 32'd2);
    chk("err_busy", 32'(busy_n), 32'd0);
    chk("err_done", 32'(done_n), 32'd0);
    chk("err_nbits", 32'(bits_n), 32'd0);

    // Loopback through the 111 detector, three repetitions
    loop_mode = 1'b1;
    step(); step();
    run_xfer(16'h0007, 3, 3);
    chk("loop_det", 32'(det_n), 32'd3);
    chk("loop_hitcnt", 32'(hit_count), 32'(det_n));
    loop_mode = 1'b0;

    // Hit held high across the longest transfer: counter saturates
    hit_drv = 1'b1;
    run_xfer(16'hFFFF, 16, 15);
    hit_drv = 1'b0;
    chk("sat_busy", 32'(busy_n), 32'(exp_busy(16, 15)));
    chk("sat_hitcnt", 32'(hit_count), 32'd255);

    // Start held high with reps=0: one pass, ignored during DONE, re-accepted after
    clear_tally();
    pattern = 16'h000A; length = LW'(4); reps = 4'd0; start = 1'b1;
    for (int i = 0; i < 12; i++) step();
    start = 1'b0;
    chk("hold_busy", 32'(busy_n), 32'd8);
    chk("hold_done", 32'(done_n), 32'd2);
    chk("hold_bits", bits, 32'hAA);
    step(); step(); step(); step(); step(); step();

    // Reset during the second bit aborts without done; next start works
    clear_tally();
    pattern = 16'h00B5; length = LW'(8); reps = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_outs", 32'({sdata, svalid, busy, done, err}), 32'd0);
    chk("rst_hitcnt", 32'(hit_count), 32'd0);
    model_reset();
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("rst_no_done", 32'(done_n), 32'd0);
    run_xfer(16'h00B5, 8, 1);
    chk("rst_after_bits", bits, 32'hB5);
    chk("rst_after_done", 32'(done_n), 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      start   = ($urandom_range(0, 3) == 0);
      pattern = MAXL'($urandom);
      length  = LW'($urandom_range(0, MAXL + 2));
      reps    = 4'($urandom_range(0, 3));
      hit_drv = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0;
    hit_drv = 1'b0;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || cur != 4'b0); i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter MAX_LEN, default 8: widest pattern in bits; range 2..16.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles inserted between repetitions; range 0..15.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request to begin a transmission; sampled on the rising edge.
REQ-007 pattern  in  MAX_LEN  bits to send; captured on start acceptance.
REQ-008 length  in  clog2(MAX_LEN+1)  number of pattern bits to send; captured on acceptance.
REQ-009 reps  in  4  repetition count; captured on acceptance; 0 is treated as 1.
REQ-010 hit  in  1  match pulse returned by the downstream sequence detector.
REQ-011 sdata  out  1  serial data bit driven to the detector's A input.
REQ-012 svalid  out  1  sdata carries a pattern bit this cycle.
REQ-013 busy  out  1  transmission in progress, from acceptance through the final bit.
REQ-014 done  out  1  single-cycle completion pulse.
REQ-015 err  out  1  single-cycle pulse on a rejected start.
REQ-016 hit_count  out  8  number of hit pulses seen while busy.

Function
REQ-017 FSM states: IDLE, SHIFT, GAP, DONE.
REQ-018 IDLE: start with length in 1..MAX_LEN -> capture inputs, clear hit_count, go to SHIFT; busy=1 from the next cycle.
REQ-019 IDLE: start with length 0 or length > MAX_LEN -> err=1 for one cycle, stay in IDLE, no capture.
REQ-020 Latency: start accepted at edge N -> first bit valid on sdata/svalid in cycle N+1.
REQ-021 SHIFT: send captured pattern[length-1] down to pattern[0], MSB first, one bit per cycle, svalid=1.
REQ-022 After bit 0: more repetitions remain -> GAP (or SHIFT directly when GAP_CYCLES=0); otherwise -> DONE.
REQ-023 GAP: sdata=0 and svalid=0 for exactly GAP_CYCLES cycles, then SHIFT with the bit index reloaded to length-1.
REQ-024 DONE: done=1 and busy=0 for one cycle, then IDLE.
REQ-025 start while busy or in DONE SHALL be ignored: no err, no effect on the transfer in progress.
REQ-026 start in the cycle after DONE (state IDLE) SHALL be accepted normally.
REQ-027 hit_count increments on each cycle with hit=1 and busy=1, saturates at 255, and holds its value in IDLE until the next acceptance.
REQ-028 A hit in the same cycle as acceptance SHALL NOT be counted; the count is cleared instead.
REQ-029 In IDLE and DONE: sdata=0, svalid=0.
REQ-030 Total busy cycles = reps_eff*length + (reps_eff-1)*GAP_CYCLES, where reps_eff = max(reps,1).

Reset
REQ-031 When reset_n=0: state IDLE; sdata, svalid, busy, done, err = 0; hit_count = 0; captured registers = 0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately; no done pulse is produced.
REQ-033 The first acceptance is possible on the first rising edge after reset_n is released.

Structure
REQ-034 Package seq_tx_pkg SHALL hold the state enum, the default MAX_LEN and GAP_CYCLES values, and the hit-counter width.
REQ-035 One sub-module, seq_tx_shreg, SHALL implement the loadable MSB-first shifter with its bit-index counter; the FSM, repetition/gap counters and hit counter stay in the top level.

Verification
REQ-036 pattern=8'b0000_0111, length=3, reps=1, start -> sdata 1,1,1 in cycles N+1..N+3; done at N+4; busy for 3 cycles.
REQ-037 pattern=3'b101, length=3, reps=2, GAP=2 -> bits 1,0,1, then 2 cycles with svalid=0, then 1,0,1; busy=8 cycles; one done pulse.
REQ-038 length=0, start -> err pulses once; busy, svalid and done stay 0.
REQ-039 Loopback to the Mealy detector (Y=A&S0&S1) via hit, pattern 111, reps=3 -> hit_count matches the detector's Y pulse count; separately, force 300 hits -> hit_count=255.
REQ-040 Reset asserted at the 2nd bit -> all outputs 0 asynchronously; no done pulse; a new start after release is accepted and sends the full pattern.
REQ-041 start held high through busy -> exactly one transfer plus re-acceptance in the cycle after DONE; reps=0 -> behaves as reps=1.
